// File: rtl/des_key_sched.sv
// -----------------------------------------------------------------------------
// des_key_sched
//   Sequential DES key-schedule generator feeding a PC-2 stage. A 64-bit key is
//   latched on start and passed through PC-1 to form C0/D0. The two 28-bit
//   halves are then rotated round by round, and C_i/D_i are presented for
//   rounds 1..16 over a valid/ready handshake. Encrypt order uses left
//   rotations. Decrypt order uses right rotations, so the downstream datapath
//   never has to store key material.
//
// Parameters:
//   PC1_BYPASS  0: apply PC-1.
//               1: key_in[1:56] is loaded directly as {C0,D0}.
//
// Optional build macro:
//   DES_KS_PARITY_CHK_EN  adds the advisory parity_err output. It is set at an
//                         accepted start when any key byte has even parity.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      load key_in/decrypt and begin a sequence (only when busy=0)
//   key_in     [1:64] DES key, bit 1 = MSB
//   decrypt    0: encrypt round order, 1: decrypt round order
//   rnd_ready  consumer accepts the current round
//   busy       sequence in progress
//   rnd_valid  c_out/d_out hold a round value
//   rnd_idx    round number minus 1
//   c_out      [1:28] C half (PC-2 li_28)
//   d_out      [1:28] D half (PC-2 ri_28)
//   done       one-cycle pulse after round 16 is accepted
//   parity_err (DES_KS_PARITY_CHK_EN only) key parity violation flag
// -----------------------------------------------------------------------------
module des_key_sched #(
  parameter int unsigned PC1_BYPASS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:64] key_in,
  input  logic        decrypt,
  input  logic        rnd_ready,
  output logic        busy,
  output logic        rnd_valid,
  output logic [3:0]  rnd_idx,
  output logic [1:28] c_out,
  output logic [1:28] d_out,
  output logic        done
`ifdef DES_KS_PARITY_CHK_EN
  ,
  output logic        parity_err
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FIN} state_t;

  state_t      state;
  logic [1:28] c0_q;
  logic [1:28] d0_q;
  logic        dec_q;

  logic [1:28] pc1_c;
  logic [1:28] pc1_d;
  logic [3:0]  nxt_idx;
  logic        one_step;

  // Rotate a 28-bit half by one or two places. Bit 1 is the MSB, so a left
  // rotate moves bit 1 around to position 28.
  function automatic logic [1:28] rot28(input logic [1:28] x,
                                        input logic        by_two,
                                        input logic        right);
    logic [1:28] y;
    if (!right)
      y = by_two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    else
      y = by_two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    return y;
  endfunction

  // PC-1 selection, or a straight load of the first 56 key bits when bypassed.
  always_comb begin
    pc1_c = '0;
    pc1_d = '0;
    if (PC1_BYPASS != 0) begin
      pc1_c = key_in[1:28];
      pc1_d = key_in[29:56];
    end else begin
      pc1_c = {key_in[57], key_in[49], key_in[41], key_in[33], key_in[25], key_in[17], key_in[9],
               key_in[1],  key_in[58], key_in[50], key_in[42], key_in[34], key_in[26], key_in[18],
               key_in[10], key_in[2],  key_in[59], key_in[51], key_in[43], key_in[35], key_in[27],
               key_in[19], key_in[11], key_in[3],  key_in[60], key_in[52], key_in[44], key_in[36]};
      pc1_d = {key_in[63], key_in[55], key_in[47], key_in[39], key_in[31], key_in[23], key_in[15],
               key_in[7],  key_in[62], key_in[54], key_in[46], key_in[38], key_in[30], key_in[22],
               key_in[14], key_in[6],  key_in[61], key_in[53], key_in[45], key_in[37], key_in[29],
               key_in[21], key_in[13], key_in[5],  key_in[28], key_in[20], key_in[12], key_in[4]};
    end
  end

  // From round 2 onward, the encrypt left-shift and decrypt right-shift
  // amounts coincide: one place when moving into rounds 2, 9 and 16, two
  // places otherwise. Round 1 is handled separately in LOAD.
  assign nxt_idx  = rnd_idx + 4'd1;
  assign one_step = (nxt_idx == 4'd1) || (nxt_idx == 4'd8) || (nxt_idx == 4'd15);

`ifdef DES_KS_PARITY_CHK_EN
  logic key_par_bad;

  // DES keys carry odd parity per byte; any even-parity byte flags the key.
  always_comb begin
    key_par_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (^key_in[8*b+1 +: 8] == 1'b0)
        key_par_bad = 1'b1;
    end
  end
`else
  logic unused_parity_bits;
  assign unused_parity_bits = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                                key_in[40], key_in[48], key_in[56], key_in[64]};
`endif

  // Sequence control. All outputs are registered. done is a default-low pulse
  // raised only on the accept of round 16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      c0_q      <= '0;
      d0_q      <= '0;
      dec_q     <= 1'b0;
      busy      <= 1'b0;
      rnd_valid <= 1'b0;
      rnd_idx   <= 4'd0;
      c_out     <= '0;
      d_out     <= '0;
      done      <= 1'b0;
`ifdef DES_KS_PARITY_CHK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            c0_q  <= pc1_c;
            d0_q  <= pc1_d;
            dec_q <= decrypt;
            busy  <= 1'b1;
`ifdef DES_KS_PARITY_CHK_EN
            parity_err <= key_par_bad;
`endif
            state <= LOAD;
          end
        end
        LOAD: begin
          // Decrypt starts from K16, whose halves C16/D16 equal C0/D0.
          c_out     <= dec_q ? c0_q : rot28(c0_q, 1'b0, 1'b0);
          d_out     <= dec_q ? d0_q : rot28(d0_q, 1'b0, 1'b0);
          rnd_idx   <= 4'd0;
          rnd_valid <= 1'b1;
          state     <= ROUND;
        end
        ROUND: begin
          if (rnd_ready) begin
            if (rnd_idx == 4'd15) begin
              rnd_valid <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end else begin
              c_out   <= rot28(c_out, !one_step, dec_q);
              d_out   <= rot28(d_out, !one_step, dec_q);
              rnd_idx <= nxt_idx;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
